// File: rtl/dice_pkg.sv
// Shared types and helpers for the serial dice prize selector.
package dice_pkg;

   localparam int unsigned FACE_MIN    = 1;
   localparam int unsigned FACE_MAX    = 6;
   localparam int unsigned PRIZE_MAX_W = 32;

   typedef enum logic [1:0] {
      COLLECT,
      EVAL,
      PRESENT
   } state_t;

   // One-hot prize for multiplicity m, clamped to the top prize bit; m=0 gives no prize.
   function automatic logic [PRIZE_MAX_W-1:0] onehot_prize(input int unsigned m,
                                                          input int unsigned num_prizes);
      int unsigned idx;
      idx = (m < num_prizes) ? m : num_prizes;
      if (idx == 0) return '0;
      return PRIZE_MAX_W'(1) << (idx - 1);
   endfunction

endpackage

// File: rtl/face_max_find.sv
// Combinational search for the most frequent face; the highest face wins ties.
module face_max_find
   import dice_pkg::*;
#(
   parameter int unsigned NUM_FACES = FACE_MAX,
   parameter int unsigned CNT_W     = 3,
   parameter int unsigned FACE_W    = 3
) (
   input  logic [NUM_FACES*CNT_W-1:0] i_counts,
   output logic [CNT_W-1:0]           o_max_cnt_c,
   output logic [FACE_W-1:0]          o_max_face_c
);

   // Ascending scan with >= lets a later (higher) face take over an equal count.
   always_comb begin
      o_max_cnt_c  = '0;
      o_max_face_c = '0;
      for (int unsigned f = FACE_MIN; f <= NUM_FACES; f++) begin
         if (i_counts[(f-1)*CNT_W +: CNT_W] >= o_max_cnt_c) begin
            o_max_cnt_c  = i_counts[(f-1)*CNT_W +: CNT_W];
            o_max_face_c = FACE_W'(f);
         end
      end
   end

endmodule

// File: rtl/dice_prize_seq.sv
// Serial dice prize selector: collects NUM_DICE dice, finds the winning face, presents a one-hot prize.
module dice_prize_seq
   import dice_pkg::*;
#(
   parameter  int unsigned NUM_DICE   = 6,
   parameter  int unsigned FACE_W     = 3,
   parameter  int unsigned NUM_FACES  = FACE_MAX,
   parameter  int unsigned NUM_PRIZES = 6,
   localparam int unsigned CNT_W      = $clog2(NUM_DICE + 1)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  abort,
   input  logic                  die_valid,
   input  logic [FACE_W-1:0]     die_value,
   output logic                  die_ready,
   output logic                  prize_valid,
   input  logic                  prize_ready,
   output logic [NUM_PRIZES-1:0] prize,
   output logic [FACE_W-1:0]     win_face,
   output logic [CNT_W-1:0]      win_count,
   output logic                  err
);

   state_t                     r_state;
   state_t                     w_nxt_state;
   logic [NUM_FACES*CNT_W-1:0] r_counts;
   logic [CNT_W-1:0]           r_dice_cnt;
   logic                       r_round_err;

   logic                       r_die_ready;
   logic                       r_prize_valid;
   logic [NUM_PRIZES-1:0]      r_prize;
   logic [FACE_W-1:0]          r_win_face;
   logic [CNT_W-1:0]           r_win_count;
   logic                       r_err;

   logic                       w_accept;
   logic                       w_clear;
   logic                       w_face_ok;
   logic                       w_nxt_ready;
   logic                       w_nxt_valid;
   logic [NUM_PRIZES-1:0]      w_nxt_prize;
   logic [FACE_W-1:0]          w_nxt_face;
   logic [CNT_W-1:0]           w_nxt_count;
   logic                       w_nxt_err;
   logic [CNT_W-1:0]           w_max_cnt;
   logic [FACE_W-1:0]          w_max_face;

   assign w_face_ok = (die_value >= FACE_W'(FACE_MIN)) && (32'(die_value) <= NUM_FACES);

   face_max_find #(
      .NUM_FACES (NUM_FACES),
      .CNT_W     (CNT_W),
      .FACE_W    (FACE_W)
   ) u_max (
      .i_counts     (r_counts),
      .o_max_cnt_c  (w_max_cnt),
      .o_max_face_c (w_max_face)
   );

   // Next state and next output values; abort outranks both die acceptance and prize_ready.
   always_comb begin
      w_nxt_state = r_state;
      w_accept    = 1'b0;
      w_clear     = 1'b0;
      w_nxt_valid = r_prize_valid;
      w_nxt_prize = r_prize;
      w_nxt_face  = r_win_face;
      w_nxt_count = r_win_count;
      w_nxt_err   = r_err;
      if (abort) begin
         w_nxt_state = COLLECT;
         w_clear     = 1'b1;
         w_nxt_valid = 1'b0;
         w_nxt_prize = '0;
         w_nxt_face  = '0;
         w_nxt_count = '0;
         w_nxt_err   = 1'b0;
      end else begin
         case (r_state)
            COLLECT: begin
               w_accept = die_valid && r_die_ready;
               if (w_accept && (r_dice_cnt == CNT_W'(NUM_DICE - 1))) w_nxt_state = EVAL;
            end
            EVAL: begin
               w_nxt_state = PRESENT;
               w_nxt_valid = 1'b1;
               if (r_round_err) begin
                  w_nxt_prize = '0;
                  w_nxt_face  = '0;
                  w_nxt_count = '0;
                  w_nxt_err   = 1'b1;
               end else begin
                  w_nxt_prize = NUM_PRIZES'(onehot_prize(32'(w_max_cnt), NUM_PRIZES));
                  w_nxt_face  = w_max_face;
                  w_nxt_count = w_max_cnt;
                  w_nxt_err   = 1'b0;
               end
            end
            PRESENT: begin
               if (prize_ready) begin
                  w_nxt_state = COLLECT;
                  w_clear     = 1'b1;
                  w_nxt_valid = 1'b0;
                  w_nxt_prize = '0;
                  w_nxt_face  = '0;
                  w_nxt_count = '0;
                  w_nxt_err   = 1'b0;
               end
            end
            default: w_nxt_state = COLLECT;
         endcase
      end
      w_nxt_ready = (w_nxt_state == COLLECT);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= COLLECT;
         r_die_ready   <= 1'b0;
         r_prize_valid <= 1'b0;
         r_prize       <= '0;
         r_win_face    <= '0;
         r_win_count   <= '0;
         r_err         <= 1'b0;
      end else begin
         r_state       <= w_nxt_state;
         r_die_ready   <= w_nxt_ready;
         r_prize_valid <= w_nxt_valid;
         r_prize       <= w_nxt_prize;
         r_win_face    <= w_nxt_face;
         r_win_count   <= w_nxt_count;
         r_err         <= w_nxt_err;
      end
   end

   // Per-face occurrence counters, dice counter and sticky invalid-die flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_counts    <= '0;
         r_dice_cnt  <= '0;
         r_round_err <= 1'b0;
      end else if (w_clear) begin
         r_counts    <= '0;
         r_dice_cnt  <= '0;
         r_round_err <= 1'b0;
      end else if (w_accept) begin
         r_dice_cnt <= r_dice_cnt + CNT_W'(1);
         if (!w_face_ok) r_round_err <= 1'b1;
         for (int unsigned f = FACE_MIN; f <= NUM_FACES; f++) begin
            if ((die_value == FACE_W'(f)) &&
                (r_counts[(f-1)*CNT_W +: CNT_W] != CNT_W'(NUM_DICE)))
               r_counts[(f-1)*CNT_W +: CNT_W] <= r_counts[(f-1)*CNT_W +: CNT_W] + CNT_W'(1);
         end
      end
   end

   assign die_ready   = r_die_ready;
   assign prize_valid = r_prize_valid;
   assign prize       = r_prize;
   assign win_face    = r_win_face;
   assign win_count   = r_win_count;
   assign err         = r_err;

endmodule

// File: doc/dice_prize_seq.md
Name: dice_prize_seq

Overview:
- Sequential, parametrised successor to the six-dice combinational prize selector.
- Accepts NUM_DICE die values serially over a valid/ready handshake and keeps a per-face occurrence count.
- When the round is complete, determines the winning face and its multiplicity, then presents a one-hot prize with a result handshake.
- Sits between the dice-roll source (LFSR or switches) and the prize display/LED logic.

Parameters:
- NUM_DICE, 6, dice per round (2..15).
- FACE_W, 3, width of a die value.
- NUM_FACES, 6, valid faces are 1..NUM_FACES; 0 and values above NUM_FACES are invalid.
- NUM_PRIZES, 6, width of the one-hot prize vector.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- abort  in  1  synchronous round cancel.
- die_valid  in  1  die_value is presented.
- die_value  in  FACE_W  face of the current die.
- die_ready  out  1  block accepts a die.
- prize_valid  out  1  result is presented.
- prize_ready  in  1  consumer takes the result.
- prize  out  NUM_PRIZES  one-hot prize; all-zero means no prize.
- win_face  out  FACE_W  winning face.
- win_count  out  CNT_W  multiplicity of win_face; CNT_W = $clog2(NUM_DICE+1).
- err  out  1  round contained at least one invalid die.

Behaviour:
- Reset (rst_n=0, async): state COLLECT, all face counters 0, dice counter 0, err flag 0.
  - Output reset values: prize_valid=0, prize=0, win_face=0, win_count=0, err=0, die_ready=0 during reset, then 1 in COLLECT.
- States: COLLECT -> EVAL -> PRESENT -> COLLECT.
- COLLECT:
  - die_ready=1. A die is accepted when die_valid && die_ready.
  - Valid face f increments count[f]. An invalid face sets the sticky round_err and is still counted as a consumed die.
  - Dice counter increments on each accepted die. The NUM_DICE-th accepted die moves the state to EVAL.
- EVAL:
  - Lasts one cycle with die_ready=0.
  - Computes max count m over faces 1..NUM_FACES. Ties resolve to the highest face.
  - Registers all outputs.
- PRESENT:
  - Begins 2 cycles after the last die is accepted. prize_valid=1, die_ready=0.
  - All outputs are held stable until prize_ready=1.
  - Handshake cycle: next cycle returns to COLLECT with counters and err flag cleared, prize_valid=0, prize=0 (win_face, win_count and err are also cleared).
- Prize mapping:
  - round_err=0: prize = one-hot bit (min(m, NUM_PRIZES) - 1); win_face = winning face; win_count = m.
  - round_err=1: prize=0, win_face=0, win_count=0, err=1.
- abort=1 in any state: next cycle COLLECT, all counters cleared, prize_valid=0.
  - abort has priority over die acceptance and over prize_ready.
  - A die offered in the same cycle as abort is not accepted.
- No wrap: per-face counters saturate at NUM_DICE, which cannot be exceeded by construction.
- Reset mid-operation: immediate return to the reset values above. Any partial round is discarded.

Decomposition:
- Package dice_pkg:
  - FACE_MIN=1, default FACE_MAX=6.
  - State enum {COLLECT, EVAL, PRESENT}.
  - Function onehot_prize(m, NUM_PRIZES).
- Sub-module face_max_find (combinational): takes the packed count vector and returns max count and winning face, highest face winning ties.
- The top level holds the FSM, counters and output registers.

Test Plan:
- Dice 4,2,3,2,1,2, one per cycle -> prize=000100, win_face=2, win_count=3, err=0, prize_valid 2 cycles after the 6th die.
- Dice 1,2,3,4,5,6 -> prize=000001, win_face=6 (tie rule), win_count=1.
- Dice 4,4,4,4,4,4 -> prize=100000, win_face=4, win_count=6. Then dice 0,2,3,2,1,2 -> err=1, prize=000000, win_face=0, win_count=0.
- Dice 3,5,7,5,5,5 (7 invalid) -> err=1, prize=000000. Hold prize_ready=0 for 5 cycles -> outputs stable, die_ready=0, extra die_valid ignored. prize_ready=1 -> next cycle die_ready=1, prize_valid=0.
- Abort after 3 dice (6,6,6), then dice 1,1,2,3,4,5 -> win_face=1, win_count=2, prize=000010.
- Drop rst_n while in PRESENT -> prize_valid=0 and prize=0 asynchronously. After release, a new round of six 5s gives prize=100000.
